// File: rtl/alu3_pkg.sv
// alu3_pkg: shared opcode type and opcode encodings for the alu_3 datapath.
//   op_t    3-bit opcode type carried on the sel signal
//   OP_*    encodings for the eight operations (all eight are legal)
package alu3_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_AND = 3'b010;
  localparam op_t OP_OR  = 3'b011;
  localparam op_t OP_XOR = 3'b100;
  localparam op_t OP_NOT = 3'b101;
  localparam op_t OP_SHL = 3'b110;
  localparam op_t OP_SHR = 3'b111;

endpackage

// File: rtl/alu_3_if.sv
// alu_3_if: operand/opcode/result bundle for alu_3.
//   a, b   operands (b doubles as shift amount)
//   sel    opcode
//   y      registered result
//   carry  registered carry/borrow flag   (only with ALU3_FLAGS_EN)
//   zero   registered zero flag           (only with ALU3_FLAGS_EN)
// Modports: master drives operands, slave (the ALU) drives results.
// Optional feature macro: ALU3_FLAGS_EN.
interface alu_3_if
  import alu3_pkg::*;
#(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_t              sel;
  logic [WIDTH-1:0] y;

`ifdef ALU3_FLAGS_EN
  logic carry;
  logic zero;

  modport master (output a, b, sel, input  y, carry, zero);
  modport slave  (input  a, b, sel, output y, carry, zero);
`else
  modport master (output a, b, sel, input  y);
  modport slave  (input  a, b, sel, output y);
`endif

endinterface

// File: rtl/alu3_shifter.sv
// alu3_shifter: combinational logical shifter for alu_3.
//   a_i     value to shift
//   b_i     shift amount; amounts >= WIDTH saturate the result to 0
//   left_i  1 = shift left, 0 = shift right (both zero fill)
//   y_o     shifted value
//   lost_o  1 when a left shift by b_i drops any 1 bit (independent of left_i)
module alu3_shifter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             left_i,
  output logic [WIDTH-1:0] y_o,
  output logic             lost_o
);

  logic               over;
  logic [2*WIDTH-1:0] wide;

  always_comb begin
    over = 32'(b_i) >= WIDTH;
    // Double-width left shift keeps the dropped bits visible in the upper half.
    wide = {{WIDTH{1'b0}}, a_i} << b_i;
    if (over) begin
      y_o    = '0;
      lost_o = |a_i;
    end else begin
      y_o    = left_i ? wide[WIDTH-1:0] : (a_i >> b_i);
      lost_o = |wide[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/alu_3.sv
// alu_3: registered eight-operation ALU, one-cycle latency, one op per cycle.
//   clk  system clock (rising edge)
//   rst  synchronous active-high reset; clears y (and flags) to 0
//   bus  alu_3_if.slave: a, b, sel in; y (and carry, zero) out
// Optional feature macro: ALU3_FLAGS_EN adds registered carry and zero flags.
module alu_3
  import alu3_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic     clk,
  input logic     rst,
  alu_3_if.slave  bus
);

  logic [WIDTH-1:0] sh_y;
  logic             sh_lost;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] y_d, y_q;
  logic             carry_d;

  alu3_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .a_i    (bus.a),
    .b_i    (bus.b),
    .left_i (bus.sel == OP_SHL),
    .y_o    (sh_y),
    .lost_o (sh_lost)
  );

  always_comb begin
    y_d      = '0;
    carry_d  = 1'b0;
    sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
    // Top bit of the extended difference is the borrow (a < b).
    diff_ext = {1'b0, bus.a} - {1'b0, bus.b};
    unique case (bus.sel)
      OP_ADD: begin
        y_d     = sum_ext[WIDTH-1:0];
        carry_d = sum_ext[WIDTH];
      end
      OP_SUB: begin
        y_d     = diff_ext[WIDTH-1:0];
        carry_d = diff_ext[WIDTH];
      end
      OP_AND: y_d = bus.a & bus.b;
      OP_OR:  y_d = bus.a | bus.b;
      OP_XOR: y_d = bus.a ^ bus.b;
      OP_NOT: y_d = ~bus.a;
      OP_SHL: begin
        y_d     = sh_y;
        carry_d = sh_lost;
      end
      OP_SHR: y_d = sh_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign bus.y = y_q;

`ifdef ALU3_FLAGS_EN
  logic carry_q, zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= (y_d == '0);
    end
  end

  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
`else
  logic unused_carry;
  assign unused_carry = carry_d;
`endif

endmodule

// File: tb/tb_alu_3.sv
// tb_alu_3: self-checking bench for alu_3. Directed cases followed by random
// operations (with occasional reset), compared against an arithmetic model.
module tb_alu_3;
  import alu3_pkg::*;

  localparam int unsigned W = 4;
  localparam int          M = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_3_if #(.WIDTH(W)) bus ();

  alu_3 #(
    .WIDTH (W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Plain-arithmetic model of one operation: result and carry/borrow.
  function automatic void ref_op(input int a, input int b, input int s,
                                 output int y, output int c);
    int full;
    y = 0;
    c = 0;
    case (s)
      0: begin y = (a + b) % M; c = (a + b >= M) ? 1 : 0; end
      1: begin y = (a - b + M) % M; c = (a < b) ? 1 : 0; end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = (M - 1) - a;
      6: begin
        if (b >= W) begin
          y = 0;
          c = (a != 0) ? 1 : 0;
        end else begin
          full = a * (1 << b);
          y = full % M;
          c = (full >= M) ? 1 : 0;
        end
      end
      default: y = (b >= W) ? 0 : a / (1 << b);
    endcase
  endfunction

  // Apply one set of inputs across a rising edge and check the registered outputs.
  task automatic step(input bit r, input int a, input int b, input int s, input string tag);
    logic [W-1:0] av, bv;
    int ey, ec, ez;
    av = W'(a);
    bv = W'(b);
    rst     = r;
    bus.a   = av;
    bus.b   = bv;
    bus.sel = 3'(s);
    ref_op(a, b, s, ey, ec);
    ez = (ey == 0) ? 1 : 0;
    if (r) begin
      ey = 0;
      ec = 0;
      ez = 0;
    end
    @(posedge clk);
    #1;
    check_eq({tag, ".y"}, int'(bus.y), ey);
`ifdef ALU3_FLAGS_EN
    check_eq({tag, ".carry"}, int'(bus.carry), ec);
    check_eq({tag, ".zero"}, int'(bus.zero), ez);
`endif
  endtask

  initial begin
    int a, b, s;
    bit r;

    // Reset held for two edges, then first live result.
    step(1'b1, 4, 2, 0, "rst0");
    step(1'b1, 4, 2, 0, "rst1");
    step(1'b0, 4, 2, 0, "first");

    // Opcode sweep with A=4, B=2.
    for (int op = 0; op < 6; op++) step(1'b0, 4, 2, op, $sformatf("sweep%0d", op));

    // Shifts, including over-range amounts.
    step(1'b0, 1, 2, 6, "shl2");
    step(1'b0, 1, 5, 6, "shl5");
    step(1'b0, 8, 1, 6, "shl_out");
    step(1'b0, 8, 2, 7, "shr2");
    step(1'b0, 8, 5, 7, "shr5");
    step(1'b0, 15, 4, 7, "shr4");

    // Wrap-around.
    step(1'b0, 15, 1, 0, "add_wrap");
    step(1'b0, 2, 4, 1, "sub_wrap");
    step(1'b0, 5, 5, 1, "sub_zero");

    // Reset in the middle of an ADD stream.
    step(1'b0, 3, 4, 0, "stream0");
    step(1'b1, 5, 6, 0, "stream_rst");
    step(1'b0, 7, 1, 0, "stream1");
    step(1'b0, 9, 9, 0, "stream2");

    // Random operations with occasional reset.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(15) == 0);
      a = $urandom_range(M - 1);
      b = $urandom_range(M - 1);
      s = $urandom_range(7);
      step(r, a, b, s, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
